// File: rtl/fpr_wb_arbiter_pkg.sv
// Shared defs for the FPR write-back arbiter: special register IDs, store modes, scoreboard mask.
// Latency: n/a (constants and a pure combinational helper).
// Backpressure: n/a.
package fpr_wb_arbiter_pkg;

  // Scoreboard width: FR0..FR31 plus FPUL in the top bit.
  localparam int SB_W = 33;
  localparam int SB_FPUL_BIT = 32;

  // Special IDs outside the FPR window (id[6:5] != 2'b10).
  localparam logic [6:0] UREG_FPUL = 7'h64;
  localparam logic [6:0] UREG_ZZR  = 7'h3F;

  // Store modes carried with every write; bit 0 set means a register pair.
  typedef enum logic [1:0] {
    ST_FLOAT  = 2'b00,
    ST_DOUBLE = 2'b01,
    ST_RAWFLT = 2'b10,
    ST_RAWDBL = 2'b11
  } stMode_t;

  // A write touches a pair whenever the store mode is one of the double forms.
  function automatic logic stIsPair(input logic [1:0] mode);
    return mode[0];
  endfunction

  // Map a register ID onto scoreboard bits; IDs outside FPR/FPUL map to nothing.
  function automatic logic [SB_W-1:0] fprSbMask(input logic [6:0] id, input logic isPair);
    logic [SB_W-1:0] m;
    m = '0;
    if (id[6:5] == 2'b10) begin
      if (isPair) begin
        m[{1'b0, id[4:1], 1'b0}] = 1'b1;
        m[{1'b0, id[4:1], 1'b1}] = 1'b1;
      end else begin
        m[{1'b0, id[4:0]}] = 1'b1;
      end
    end else if (id == UREG_FPUL) begin
      m[SB_FPUL_BIT] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/fpr_sb_mask.sv
// Decodes one register ID (single or pair) into a 33-bit scoreboard mask.
// Latency: combinational.
// Backpressure: none.
module fpr_sb_mask
  import fpr_wb_arbiter_pkg::*;
(
  input  logic [6:0]      id,
  input  logic            isPair,
  output logic [SB_W-1:0] mask
);

  assign mask = fprSbMask(id, isPair);

endmodule

// File: rtl/fpr_wb_arbiter.sv
// Arbitrates FPU and load results onto the single FPR/FPUL write port and tracks pending writes.
// Latency: one cycle from grant to the registered write port; scoreboard bits clear at the commit edge.
// Backpressure: the loser of a conflict waits with valid held; the port itself never stalls. FPR_WB_RR_EN selects round-robin.
module fpr_wb_arbiter
  import fpr_wb_arbiter_pkg::*;
(
  input  logic            clock,
  input  logic            reset,

  input  logic            fpuValid,
  output logic            fpuReady,
  input  logic [6:0]      fpuId,
  input  logic [63:0]     fpuVal,
  input  logic [1:0]      fpuStMode,

  input  logic            ldValid,
  output logic            ldReady,
  input  logic [6:0]      ldId,
  input  logic [63:0]     ldVal,
  input  logic [1:0]      ldStMode,

  input  logic            issueValid,
  input  logic [6:0]      issueIdRs,
  input  logic [6:0]      issueIdRt,
  input  logic [6:0]      issueIdRm,
  input  logic [6:0]      issueIdRn,
  input  logic            issueDbl,
  output logic            issueOk,

  output logic [6:0]      regIdRn,
  output logic [63:0]     regValRn,
  output logic [1:0]      regStMode,

  output logic [SB_W-1:0] sbBusy
);

  logic [SB_W-1:0] maskRs;
  logic [SB_W-1:0] maskRt;
  logic [SB_W-1:0] maskRm;
  logic [SB_W-1:0] maskRn;
  logic [SB_W-1:0] maskWb;
  logic [SB_W-1:0] sbSet;
  logic            wbPair;
  logic            issueFire;
  logic            fpuGrant;
  logic            ldGrant;

  fpr_sb_mask uMaskRs (.id(issueIdRs), .isPair(issueDbl), .mask(maskRs));
  fpr_sb_mask uMaskRt (.id(issueIdRt), .isPair(issueDbl), .mask(maskRt));
  fpr_sb_mask uMaskRm (.id(issueIdRm), .isPair(issueDbl), .mask(maskRm));
  fpr_sb_mask uMaskRn (.id(issueIdRn), .isPair(issueDbl), .mask(maskRn));

  // The write sitting in the output stage retires at the next edge, so its bits clear there.
  assign wbPair = stIsPair(regStMode);
  fpr_sb_mask uMaskWb (.id(regIdRn), .isPair(wbPair), .mask(maskWb));

  // Rn is part of the check so a second writer to a busy register (WAW) also waits.
  assign issueOk   = ~|(sbBusy & (maskRs | maskRt | maskRm | maskRn));
  assign issueFire = issueValid && issueOk;
  assign sbSet     = issueFire ? maskRn : '0;

`ifdef FPR_WB_RR_EN
  // High when the FPU took the most recent grant, so the load wins the next conflict.
  logic rrLastFpu;

  // Grant: sole requester wins; on conflict the side that did not win last goes.
  always_comb begin
    fpuGrant = 1'b0;
    ldGrant  = 1'b0;
    if (!reset) begin
      if (fpuValid && ldValid) begin
        fpuGrant = !rrLastFpu;
        ldGrant  = rrLastFpu;
      end else begin
        fpuGrant = fpuValid;
        ldGrant  = ldValid;
      end
    end
  end

  // Pointer follows every grant; reset leaves it favouring the FPU.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rrLastFpu <= 1'b0;
    end else if (fpuGrant || ldGrant) begin
      rrLastFpu <= fpuGrant;
    end
  end
`else
  // Grant: fixed priority, the FPU always beats the load unit.
  always_comb begin
    fpuGrant = !reset && fpuValid;
    ldGrant  = !reset && ldValid && !fpuValid;
  end
`endif

  assign fpuReady = fpuGrant;
  assign ldReady  = ldGrant;

  // Output stage: hold the granted write for one port cycle, otherwise park on ZZR.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regIdRn   <= UREG_ZZR;
      regValRn  <= '0;
      regStMode <= ST_FLOAT;
    end else if (fpuGrant) begin
      regIdRn   <= fpuId;
      regValRn  <= fpuVal;
      regStMode <= fpuStMode;
    end else if (ldGrant) begin
      regIdRn   <= ldId;
      regValRn  <= ldVal;
      regStMode <= ldStMode;
    end else begin
      regIdRn   <= UREG_ZZR;
      regValRn  <= '0;
      regStMode <= ST_FLOAT;
    end
  end

  // Scoreboard: retire the committing write, then set the new destination (set wins).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sbBusy <= '0;
    end else begin
      sbBusy <= (sbBusy & ~maskWb) | sbSet;
    end
  end

endmodule

// File: tb/tb_fpr_wb_arbiter.sv
// Bench for fpr_wb_arbiter: directed scenarios followed by random traffic against a reference model.
// Latency: model expects writes on the port one cycle after grant.
// Backpressure: bench producers hold valid and payload until granted.
module tb_fpr_wb_arbiter;
  import fpr_wb_arbiter_pkg::*;

`ifdef FPR_WB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic        fpuValid;
  logic        fpuReady;
  logic [6:0]  fpuId;
  logic [63:0] fpuVal;
  logic [1:0]  fpuStMode;
  logic        ldValid;
  logic        ldReady;
  logic [6:0]  ldId;
  logic [63:0] ldVal;
  logic [1:0]  ldStMode;
  logic        issueValid;
  logic [6:0]  issueIdRs;
  logic [6:0]  issueIdRt;
  logic [6:0]  issueIdRm;
  logic [6:0]  issueIdRn;
  logic        issueDbl;
  logic        issueOk;
  logic [6:0]  regIdRn;
  logic [63:0] regValRn;
  logic [1:0]  regStMode;
  logic [32:0] sbBusy;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state
  logic [32:0] mBusy;
  logic [6:0]  mOutId;
  logic [63:0] mOutVal;
  logic [1:0]  mOutMode;
  int          lastWinner;    // 0 = FPU, 1 = load
  bit          lastFpuGrant;
  bit          lastLdGrant;

  fpr_wb_arbiter dut (
    .clock(clock), .reset(reset),
    .fpuValid(fpuValid), .fpuReady(fpuReady), .fpuId(fpuId), .fpuVal(fpuVal), .fpuStMode(fpuStMode),
    .ldValid(ldValid), .ldReady(ldReady), .ldId(ldId), .ldVal(ldVal), .ldStMode(ldStMode),
    .issueValid(issueValid), .issueIdRs(issueIdRs), .issueIdRt(issueIdRt), .issueIdRm(issueIdRm),
    .issueIdRn(issueIdRn), .issueDbl(issueDbl), .issueOk(issueOk),
    .regIdRn(regIdRn), .regValRn(regValRn), .regStMode(regStMode), .sbBusy(sbBusy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Which scoreboard entries a register reference occupies, from the bit-mapping rules.
  function automatic logic [32:0] refMask(input logic [6:0] id, input logic pair);
    logic [32:0] m;
    int r;
    m = '0;
    if (id == UREG_FPUL) begin
      m[32] = 1'b1;
    end else if (id >= 7'h40 && id <= 7'h5F) begin
      r = int'(id) - 64;
      if (pair) begin
        m[(r / 2) * 2]     = 1'b1;
        m[(r / 2) * 2 + 1] = 1'b1;
      end else begin
        m[r] = 1'b1;
      end
    end
    return m;
  endfunction

  task automatic modelReset();
    mBusy      = '0;
    mOutId     = UREG_ZZR;
    mOutVal    = '0;
    mOutMode   = 2'b00;
    lastWinner = 1;
    lastFpuGrant = 1'b0;
    lastLdGrant  = 1'b0;
  endtask

  // Check the cycle's outputs against the model, advance the model, and move to the next low phase.
  task automatic stepCycle();
    bit expF, expL, expOk;
    logic [32:0] clrM, setM, rdM;
    #1;
    expF = 1'b0;
    expL = 1'b0;
    if (fpuValid && ldValid) begin
      if (RR_MODE && lastWinner == 0) expL = 1'b1;
      else expF = 1'b1;
    end else if (fpuValid) begin
      expF = 1'b1;
    end else if (ldValid) begin
      expL = 1'b1;
    end
    rdM = refMask(issueIdRs, issueDbl) | refMask(issueIdRt, issueDbl) |
          refMask(issueIdRm, issueDbl) | refMask(issueIdRn, issueDbl);
    expOk = ((mBusy & rdM) == 33'h0);

    checkVal("fpuReady", {63'h0, fpuReady}, {63'h0, expF});
    checkVal("ldReady", {63'h0, ldReady}, {63'h0, expL});
    checkVal("issueOk", {63'h0, issueOk}, {63'h0, expOk});
    checkVal("regIdRn", {57'h0, regIdRn}, {57'h0, mOutId});
    checkVal("regValRn", regValRn, mOutVal);
    checkVal("regStMode", {62'h0, regStMode}, {62'h0, mOutMode});
    checkVal("sbBusy", {31'h0, sbBusy}, {31'h0, mBusy});

    clrM  = refMask(mOutId, (mOutMode == 2'b01) || (mOutMode == 2'b11));
    setM  = (issueValid && expOk) ? refMask(issueIdRn, issueDbl) : 33'h0;
    mBusy = (mBusy & ~clrM) | setM;
    if (expF) begin
      mOutId = fpuId; mOutVal = fpuVal; mOutMode = fpuStMode; lastWinner = 0;
    end else if (expL) begin
      mOutId = ldId; mOutVal = ldVal; mOutMode = ldStMode; lastWinner = 1;
    end else begin
      mOutId = UREG_ZZR; mOutVal = '0; mOutMode = 2'b00;
    end
    lastFpuGrant = expF;
    lastLdGrant  = expL;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic setIssue(input logic v, input logic [6:0] rs, input logic [6:0] rt,
                          input logic [6:0] rm, input logic [6:0] rn, input logic dbl);
    issueValid = v; issueIdRs = rs; issueIdRt = rt; issueIdRm = rm; issueIdRn = rn; issueDbl = dbl;
  endtask

  function automatic logic [6:0] randId();
    int k;
    logic [6:0] id;
    k = $urandom_range(0, 9);
    if (k <= 6) id = 7'h40 + 7'($urandom_range(0, 31));
    else if (k == 7) id = UREG_FPUL;
    else if (k == 8) id = UREG_ZZR;
    else id = 7'($urandom_range(0, 63));
    return id;
  endfunction

  initial begin
    reset = 1'b1;
    fpuValid = 1'b0; fpuId = UREG_ZZR; fpuVal = '0; fpuStMode = 2'b00;
    ldValid = 1'b0;  ldId = UREG_ZZR;  ldVal = '0;  ldStMode = 2'b00;
    setIssue(1'b0, UREG_ZZR, UREG_ZZR, UREG_ZZR, UREG_ZZR, 1'b0);
    modelReset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkVal("rstSbBusy", {31'h0, sbBusy}, 64'h0);
    checkVal("rstRegId", {57'h0, regIdRn}, {57'h0, UREG_ZZR});
    checkVal("rstRegVal", regValRn, 64'h0);

    // Single FPU write to FR3 after FR3 was issued
    setIssue(1'b1, UREG_ZZR, UREG_ZZR, UREG_ZZR, 7'h43, 1'b0);
    stepCycle();
    setIssue(1'b0, UREG_ZZR, UREG_ZZR, UREG_ZZR, UREG_ZZR, 1'b0);
    fpuValid = 1'b1; fpuId = 7'h43; fpuStMode = 2'b00; fpuVal = 64'h3FF0000000000000;
    #1;
    checkVal("t1FpuReady", {63'h0, fpuReady}, 64'h1);
    checkVal("t1Busy3Set", {63'h0, sbBusy[3]}, 64'h1);
    stepCycle();
    fpuValid = 1'b0;
    #1;
    checkVal("t1RegId", {57'h0, regIdRn}, 64'h43);
    checkVal("t1RegVal", regValRn, 64'h3FF0000000000000);
    stepCycle();
    #1;
    checkVal("t1Busy3Clr", {63'h0, sbBusy[3]}, 64'h0);

    // Double issue to FR4/FR5, blocked reader, load writeback of the pair
    setIssue(1'b1, UREG_ZZR, UREG_ZZR, UREG_ZZR, 7'h44, 1'b1);
    stepCycle();
    setIssue(1'b1, 7'h45, UREG_ZZR, UREG_ZZR, UREG_ZZR, 1'b0);
    #1;
    checkVal("t2BusyPair", {62'h0, sbBusy[5:4]}, 64'h3);
    checkVal("t2ReaderBlocked", {63'h0, issueOk}, 64'h0);
    stepCycle();
    setIssue(1'b0, UREG_ZZR, UREG_ZZR, UREG_ZZR, UREG_ZZR, 1'b0);
    ldValid = 1'b1; ldId = 7'h44; ldStMode = 2'b01; ldVal = 64'h4000000000000000;
    stepCycle();
    ldValid = 1'b0;
    stepCycle();
    setIssue(1'b1, 7'h45, UREG_ZZR, UREG_ZZR, UREG_ZZR, 1'b0);
    #1;
    checkVal("t2PairClr", {62'h0, sbBusy[5:4]}, 64'h0);
    checkVal("t2ReaderOk", {63'h0, issueOk}, 64'h1);
    stepCycle();
    setIssue(1'b0, UREG_ZZR, UREG_ZZR, UREG_ZZR, UREG_ZZR, 1'b0);

    // Conflict: both producers valid
    fpuValid = 1'b1; fpuId = 7'h48; fpuVal = 64'h11; fpuStMode = 2'b00;
    ldValid  = 1'b1; ldId  = 7'h49; ldVal  = 64'h22; ldStMode  = 2'b00;
`ifdef FPR_WB_RR_EN
    for (int k = 0; k < 4; k++) begin
      #1;
      checkVal("rrFpuReady", {63'h0, fpuReady}, {63'h0, (k % 2) == 0});
      checkVal("rrLdReady", {63'h0, ldReady}, {63'h0, (k % 2) == 1});
      stepCycle();
      #1;
      checkVal("rrRegId", {57'h0, regIdRn}, ((k % 2) == 0) ? 64'h48 : 64'h49);
    end
    fpuValid = 1'b0;
    ldValid  = 1'b0;
    stepCycle();
`else
    for (int k = 0; k < 3; k++) begin
      #1;
      checkVal("fixFpuReady", {63'h0, fpuReady}, 64'h1);
      checkVal("fixLdReady", {63'h0, ldReady}, 64'h0);
      stepCycle();
      #1;
      checkVal("fixRegId", {57'h0, regIdRn}, 64'h48);
    end
    fpuValid = 1'b0;
    #1;
    checkVal("fixLdGranted", {63'h0, ldReady}, 64'h1);
    stepCycle();
    ldValid = 1'b0;
    #1;
    checkVal("fixLdRegId", {57'h0, regIdRn}, 64'h49);
    stepCycle();
`endif

    // FPUL tracking
    setIssue(1'b1, UREG_ZZR, UREG_ZZR, UREG_ZZR, UREG_FPUL, 1'b0);
    stepCycle();
    setIssue(1'b1, UREG_ZZR, UREG_FPUL, UREG_ZZR, UREG_ZZR, 1'b0);
    #1;
    checkVal("t5FpulBusy", {63'h0, sbBusy[32]}, 64'h1);
    checkVal("t5FpulBlocked", {63'h0, issueOk}, 64'h0);
    stepCycle();
    setIssue(1'b0, UREG_ZZR, UREG_ZZR, UREG_ZZR, UREG_ZZR, 1'b0);
    fpuValid = 1'b1; fpuId = UREG_FPUL; fpuVal = 64'h3F800000; fpuStMode = 2'b00;
    stepCycle();
    fpuValid = 1'b0;
    stepCycle();
    #1;
    checkVal("t5FpulClr", {63'h0, sbBusy[32]}, 64'h0);

    // Asynchronous reset with busy bits and a write in the output stage
    setIssue(1'b1, UREG_ZZR, UREG_ZZR, UREG_ZZR, 7'h44, 1'b0);
    stepCycle();
    setIssue(1'b1, UREG_ZZR, UREG_ZZR, UREG_ZZR, UREG_FPUL, 1'b0);
    stepCycle();
    setIssue(1'b0, UREG_ZZR, UREG_ZZR, UREG_ZZR, UREG_ZZR, 1'b0);
    fpuValid = 1'b1; fpuId = 7'h47; fpuVal = 64'h77; fpuStMode = 2'b00;
    #1;
    checkVal("t6BusyBefore", {31'h0, sbBusy}, 64'h1_0000_0010);
    stepCycle();
    ldValid = 1'b1; ldId = 7'h4A; ldVal = 64'h88; ldStMode = 2'b00;
    #1;
    checkVal("t6OutHeld", {57'h0, regIdRn}, 64'h47);
    #1;
    reset = 1'b1;
    #1;
    checkVal("t6AsyncBusy", {31'h0, sbBusy}, 64'h0);
    checkVal("t6AsyncRegId", {57'h0, regIdRn}, {57'h0, UREG_ZZR});
    checkVal("t6AsyncRegVal", regValRn, 64'h0);
    checkVal("t6FpuRdyRst", {63'h0, fpuReady}, 64'h0);
    checkVal("t6LdRdyRst", {63'h0, ldReady}, 64'h0);
    @(posedge clock);
    #1;
    checkVal("t6FpuRdyRst2", {63'h0, fpuReady}, 64'h0);
    checkVal("t6LdRdyRst2", {63'h0, ldReady}, 64'h0);
    checkVal("t6BusyRst2", {31'h0, sbBusy}, 64'h0);
    @(negedge clock);
    reset = 1'b0;
    fpuValid = 1'b0;
    ldValid  = 1'b0;
    modelReset();
    stepCycle();

    // Random traffic against the model
    for (int c = 0; c < 800; c++) begin
      if (!fpuValid || lastFpuGrant) begin
        fpuValid  = ($urandom_range(0, 2) != 0);
        fpuId     = randId();
        fpuVal    = {$urandom, $urandom};
        fpuStMode = 2'($urandom_range(0, 3));
      end
      if (!ldValid || lastLdGrant) begin
        ldValid  = ($urandom_range(0, 2) != 0);
        ldId     = randId();
        ldVal    = {$urandom, $urandom};
        ldStMode = 2'($urandom_range(0, 3));
      end
      setIssue(($urandom_range(0, 1) != 0), randId(), randId(), randId(), randId(),
               ($urandom_range(0, 3) == 0));
      stepCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule

// File: doc/fpr_wb_arbiter.md
# fpr_wb_arbiter

Write-port arbiter and hazard scoreboard for the floating-point register file. Two producers, the FPU result pipeline and the memory load unit, compete for the single FPR/FPUL write port (`regIdRn`/`regValRn`/`regStMode`). The block grants one write per cycle, registers it onto the port, and keeps a per-register pending scoreboard. The issue stage uses that scoreboard to hold instructions whose FPR or FPUL operands or destination are still in flight.

## Interface
Parameters: none. Register IDs, `UREG_FPUL` and `UREG_ZZR` come from the shared defs.

Ports:
- `clock` in 1: core clock; everything updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `fpuValid` in 1: FPU result pending.
- `fpuReady` out 1: FPU result accepted this cycle.
- `fpuId` in 7: FPU destination ID.
- `fpuVal` in 64: FPU result.
- `fpuStMode` in 2: FPU store mode (00 float, 01 double, 10 raw float, 11 raw double).
- `ldValid`, `ldReady`, `ldId`, `ldVal`, `ldStMode`: the same set for the load unit.
- `issueValid` in 1: the issue stage wants to issue an FPR-touching instruction.
- `issueIdRs`, `issueIdRt`, `issueIdRm`, `issueIdRn` in 7 each: source and destination IDs.
- `issueDbl` in 1: operands are register pairs.
- `issueOk` out 1: no hazard. An issue occurs when `issueValid && issueOk`.
- `regIdRn` out 7: write ID to the FPR file.
- `regValRn` out 64: write data.
- `regStMode` out 2: write store mode.
- `sbBusy` out 33: scoreboard. Bits 0..31 are FR0..FR31; bit 32 is FPUL.

## Operation
- **Scoreboard bit mapping:**
  - An FPR ID (`id[6:5]==2'b10`) maps to bit `id[4:0]`.
  - `UREG_FPUL` maps to bit 32.
  - Any other ID maps to no bit.
  - Pair access covers both bits `{id[4:1],0}` and `{id[4:1],1}`.
    - Reads are pair accesses when `issueDbl` is set.
    - Writes are pair accesses when store mode is 01 or 11.
- **Hazard check:** `issueOk` is low when any mapped bit of Rs, Rt, Rm or Rn is set. Checking Rn covers WAW hazards. The check is combinational.
- **Set:** on an issue, the Rn bits (pair if `issueDbl`) are set at the edge.
- **Clear:** the bits of the write held in the output stage are cleared at the edge that ends its port cycle.
- **Set and clear on the same bit in the same edge:** set wins.
- **Arbitration:**
  - If exactly one producer is valid, it is granted.
  - If both are valid, the winner is chosen per the Configuration section.
  - `fpuReady` and `ldReady` are the grant signals, which are combinational from the valid inputs and the arbiter state.
  - The loser holds its request; its valid and payload must stay stable until granted.
- **Output stage:** a granted request is loaded into the output register. With no grant, the output loads `regIdRn=UREG_ZZR`, `regValRn=0`, `regStMode=00`.
- **Non-FPR/non-FPUL IDs:** still granted and passed through unchanged; no scoreboard effect.
- **Reset (including mid-operation):**
  - `sbBusy=0` and all in-flight state is discarded.
  - Output stage is `UREG_ZZR`/0/00.
  - Round-robin pointer selects the FPU next.
  - Both ready outputs are low while `reset` is high.

## Timing
- **Accept:** edge E0 with valid&&ready high.
- **Write:** `regIdRn`/`regValRn`/`regStMode` are driven throughout the following cycle and commit in the FPR file at edge E1.
- **Scoreboard release:** the destination bits clear at E1. `issueOk` for that register goes high in the cycle after E1.
- **Throughput and latency:** one write per cycle; write latency of one cycle from acceptance. The port never back-pressures.
- **Issue-to-retire in the same cycle:** cannot occur on the same bit, because `issueOk` is low while the bit is busy.

## Configuration
- `FPR_WB_RR_EN` defined:
  - Round-robin between the two producers on conflict.
  - A one-bit pointer records the last grantee and updates on every grant.
  - Reset state favours the FPU.
- `FPR_WB_RR_EN` undefined: fixed priority, FPU over load. The pointer flop is absent.

## Structure
- **Shared defs:** `UREG_FPUL`, `UREG_ZZR`, the store-mode encodings, and the ID-to-scoreboard-mask function.
- **Sub-module `fpr_sb_mask`:** combinational. Inputs are ID and pair flag; output is the 33-bit mask. One instance each for Rs, Rt, Rm, Rn, plus one for the output-stage write.

## Test plan
- **Single FPU write:** `fpuValid`, `fpuId=7'h43` (FR3), `fpuStMode=00`, `fpuVal=64'h3FF0000000000000`.
  - `fpuReady=1` at E0.
  - Next cycle: `regIdRn=7'h43` with that value; `sbBusy[3]` clears at E1.
- **Double issue then writeback:** issue with `issueIdRn=7'h44`, `issueDbl=1`.
  - `sbBusy[5:4]=2'b11`.
  - A later issue reading `7'h45` gets `issueOk=0`.
  - After a load writeback to `7'h44` with `ldStMode=01`, both bits clear and `issueOk=1` the following cycle.
- **Conflict with `FPR_WB_RR_EN` defined:** both producers valid for 4 cycles.
  - Grants go FPU, load, FPU, load; the output IDs alternate accordingly.
- **Conflict without `FPR_WB_RR_EN`:** both producers valid for 3 cycles.
  - FPU is granted every cycle and `ldReady` stays 0.
  - The load request is granted the cycle after `fpuValid` drops.
- **FPUL tracking:** issue with `issueIdRn=UREG_FPUL`.
  - `sbBusy[32]=1` and `issueOk=0` for a reader with `issueIdRt=UREG_FPUL`.
  - After FPU writeback to `UREG_FPUL`, the bit clears.
- **Async reset mid-operation:** assert `reset` between edges while `sbBusy=33'h1_0000_0010` and the output stage holds a write.
  - `sbBusy=0` and `regIdRn=UREG_ZZR` immediately, without waiting for a clock edge.
  - Both ready outputs are low until `reset` is released.
